// File: rtl/des_block_tx_serializer.sv
// -----------------------------------------------------------------------------
// des_block_tx_serializer
//
// Takes one DES result block through a valid/ready handshake, cuts it into
// bytes and hands the bytes one at a time to the UART transmitter through its
// send/ready handshake. Streams ciphertext or plaintext off-board.
//
// Optional build macro: DES_SER_HEX_ASCII_EN
//   Defined   : each byte goes out as two uppercase ASCII hex characters
//               (high nibble first), followed by CR (8'h0D) and LF (8'h0A)
//               after the last byte of the block. That is 2*BLOCK_BYTES+2
//               UART transfers per block.
//   Undefined : raw binary, BLOCK_BYTES transfers per block.
//
// Parameters:
//   BLOCK_BYTES : bytes per block (8 for a 64-bit DES block)
//   MSB_FIRST   : 1 = in_data[63:56] leaves first, 0 = in_data[7:0] first
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous, active-high reset
//   in_data   in   block to transmit (8*BLOCK_BYTES bits)
//   in_valid  in   in_data valid
//   in_ready  out  serializer can accept a block
//   tx_data   out  byte/character for the UART transmitter
//   send      out  send request to the UART transmitter
//   tx_ready  in   UART transmitter idle
//   busy      out  block in progress
//   done      out  one-cycle pulse after the last transfer of a block
// -----------------------------------------------------------------------------
module des_block_tx_serializer #(
    parameter int BLOCK_BYTES = 8,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [8*BLOCK_BYTES-1:0]   in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [7:0]                 tx_data,
    output logic                       send,
    input  logic                       tx_ready,
    output logic                       busy,
    output logic                       done
);

    localparam int DATA_W = 8 * BLOCK_BYTES;
    localparam int IDX_W  = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TX,
        SEND,
        WAIT_ACK,
        WAIT_DONE,
        FINISH
    } state_t;

    state_t             state_reg;
    logic [DATA_W-1:0]  buf_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               in_ready_reg;
    logic [7:0]         tx_data_reg;
    logic               send_reg;
    logic               busy_reg;
    logic               done_reg;

    // Byte lanes of the captured block, already in transmission order, so
    // lane[k] is always the k-th byte to leave regardless of MSB_FIRST.
    logic [7:0] lane [BLOCK_BYTES];

    generate
        for (genvar gi = 0; gi < BLOCK_BYTES; gi++) begin : g_lane
            if (MSB_FIRST) begin : g_msb
                assign lane[gi] = buf_reg[DATA_W-1-8*gi -: 8];
            end else begin : g_lsb
                assign lane[gi] = buf_reg[8*gi +: 8];
            end
        end
    endgenerate

    logic [IDX_W-1:0] idx_next;
    logic             last_byte;
    logic [7:0]       first_char;
    logic [7:0]       next_char;
    logic             more_chars;

    assign idx_next  = idx_reg + 1'b1;
    assign last_byte = (idx_reg == IDX_W'(BLOCK_BYTES - 1));

`ifdef DES_SER_HEX_ASCII_EN
    // Character position inside the block: byte index, nibble phase
    // (0 = high nibble on the line) and trailer step (0 = data,
    // 1 = CR on the line, 2 = LF on the line).
    logic       nib_reg;
    logic [1:0] trl_reg;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign first_char = hex_char(lane[0][7:4]);

    always_comb begin
        more_chars = 1'b1;
        next_char  = 8'h00;
        if (trl_reg == 2'd0) begin
            if (!nib_reg) begin
                next_char = hex_char(lane[idx_reg][3:0]);
            end else if (!last_byte) begin
                next_char = hex_char(lane[idx_next][7:4]);
            end else begin
                next_char = 8'h0D;
            end
        end else if (trl_reg == 2'd1) begin
            next_char = 8'h0A;
        end else begin
            more_chars = 1'b0;
        end
    end
`else
    assign first_char = lane[0];
    assign next_char  = lane[idx_next];
    assign more_chars = !last_byte;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            buf_reg      <= '0;
            idx_reg      <= '0;
            in_ready_reg <= 1'b1;
            tx_data_reg  <= 8'h00;
            send_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
`ifdef DES_SER_HEX_ASCII_EN
            nib_reg      <= 1'b0;
            trl_reg      <= 2'd0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    in_ready_reg <= 1'b1;
                    done_reg     <= 1'b0;
                    if (in_valid && in_ready_reg) begin
                        buf_reg      <= in_data;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        idx_reg      <= '0;
`ifdef DES_SER_HEX_ASCII_EN
                        nib_reg      <= 1'b0;
                        trl_reg      <= 2'd0;
`endif
                        state_reg    <= WAIT_TX;
                    end
                end

                WAIT_TX: begin
                    if (tx_ready) begin
                        tx_data_reg <= first_char;
                        send_reg    <= 1'b1;
                        state_reg   <= SEND;
                    end
                end

                // send stays high until the UART shows it latched the byte
                // by dropping tx_ready; a lingering send is harmless since
                // the UART ignores it outside idle.
                SEND, WAIT_ACK: begin
                    if (!tx_ready) begin
                        send_reg  <= 1'b0;
                        state_reg <= WAIT_DONE;
                    end else begin
                        state_reg <= WAIT_ACK;
                    end
                end

                WAIT_DONE: begin
                    if (tx_ready) begin
                        if (more_chars) begin
                            tx_data_reg <= next_char;
                            send_reg    <= 1'b1;
                            state_reg   <= SEND;
`ifdef DES_SER_HEX_ASCII_EN
                            if (trl_reg == 2'd0) begin
                                if (!nib_reg) begin
                                    nib_reg <= 1'b1;
                                end else if (!last_byte) begin
                                    idx_reg <= idx_next;
                                    nib_reg <= 1'b0;
                                end else begin
                                    trl_reg <= 2'd1;
                                end
                            end else begin
                                trl_reg <= 2'd2;
                            end
`else
                            idx_reg     <= idx_next;
`endif
                        end else begin
                            // done is raised on entry so it is high for
                            // exactly the one cycle spent in FINISH.
                            done_reg  <= 1'b1;
                            state_reg <= FINISH;
                        end
                    end
                end

                FINISH: begin
                    done_reg     <= 1'b0;
                    busy_reg     <= 1'b0;
                    in_ready_reg <= 1'b1;
                    state_reg    <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready = in_ready_reg;
    assign tx_data  = tx_data_reg;
    assign send     = send_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_des_block_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_des_block_tx_serializer
//
// Two serializers (MSB_FIRST=1 and MSB_FIRST=0) share the block input and
// each talks to its own UART model, which holds tx_ready low for a fixed
// number of cycles after latching a byte. Directed vectors carry the
// hand-computed byte order for both instances.
// -----------------------------------------------------------------------------
module tb_des_block_tx_serializer;

    localparam int UART_HOLD = 20;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [63:0] in_data;
    logic        in_valid;
    logic [1:0]  in_ready_s;
    logic [1:0]  send_s;
    logic [1:0]  busy_s;
    logic [1:0]  done_s;
    logic [1:0]  tx_ready_s = 2'b11;
    logic [7:0]  tx_data_m;
    logic [7:0]  tx_data_l;

    des_block_tx_serializer #(.BLOCK_BYTES(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready_s[0]),
        .tx_data  (tx_data_m),
        .send     (send_s[0]),
        .tx_ready (tx_ready_s[0]),
        .busy     (busy_s[0]),
        .done     (done_s[0])
    );

    des_block_tx_serializer #(.BLOCK_BYTES(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready_s[1]),
        .tx_data  (tx_data_l),
        .send     (send_s[1]),
        .tx_ready (tx_ready_s[1]),
        .busy     (busy_s[1]),
        .done     (done_s[1])
    );

    // ---------------- UART models (update on the falling edge) -------------
    int         cnt [2] = '{0, 0};
    int         done_cnt [2] = '{0, 0};
    bit         hold_low = 1'b0;
    logic [7:0] rx_q0 [$];
    logic [7:0] rx_q1 [$];
    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (done_s[u]) done_cnt[u]++;
            if (send_s[u] && tx_ready_s[u]) begin
                if (u == 0) rx_q0.push_back(tx_data_m);
                else        rx_q1.push_back(tx_data_l);
                tx_ready_s[u] = 1'b0;
                cnt[u] = UART_HOLD;
            end else if (cnt[u] > 0) begin
                cnt[u]--;
            end else begin
                tx_ready_s[u] = !hold_low;
            end
        end
    end

    // ---------------- checking helpers ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] asc(input logic [3:0] n);
        if (n > 4'd9) return "A" + 8'(n - 4'd10);
        return "0" + 8'(n);
    endfunction

    // Expected UART stream from a list of bytes (packed, first byte on top).
    task automatic build_exp(input logic [63:0] s0, input logic [63:0] s1);
        logic [7:0] b0, b1;
        exp_q0.delete();
        exp_q1.delete();
        for (int k = 0; k < 8; k++) begin
            b0 = s0[63-8*k -: 8];
            b1 = s1[63-8*k -: 8];
`ifdef DES_SER_HEX_ASCII_EN
            exp_q0.push_back(asc(b0[7:4])); exp_q0.push_back(asc(b0[3:0]));
            exp_q1.push_back(asc(b1[7:4])); exp_q1.push_back(asc(b1[3:0]));
`else
            exp_q0.push_back(b0);
            exp_q1.push_back(b1);
`endif
        end
`ifdef DES_SER_HEX_ASCII_EN
        exp_q0.push_back(8'h0D); exp_q0.push_back(8'h0A);
        exp_q1.push_back(8'h0D); exp_q1.push_back(8'h0A);
`endif
    endtask

    task automatic check_streams(input string tag);
        chk($sformatf("%s msb_count", tag), 64'(rx_q0.size()), 64'(exp_q0.size()));
        chk($sformatf("%s lsb_count", tag), 64'(rx_q1.size()), 64'(exp_q1.size()));
        for (int k = 0; k < exp_q0.size(); k++)
            chk($sformatf("%s msb[%0d]", tag, k),
                (k < rx_q0.size()) ? 64'(rx_q0[k]) : 64'hBAD, 64'(exp_q0[k]));
        for (int k = 0; k < exp_q1.size(); k++)
            chk($sformatf("%s lsb[%0d]", tag, k),
                (k < rx_q1.size()) ? 64'(rx_q1[k]) : 64'hBAD, 64'(exp_q1[k]));
    endtask

    // One block end to end: accept, first-send latency, completion, done.
    task automatic run_block(input logic [63:0] d, input logic [63:0] e_msb,
                             input logic [63:0] e_lsb, input int hold,
                             input bit pulse, input string tag);
        int  d0, d1;
        bit  bad, timeout;
        build_exp(e_msb, e_lsb);
        rx_q0.delete();
        rx_q1.delete();
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        if (hold > 0) hold_low = 1'b1;
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk({tag, " accept_in_ready"}, 64'(in_ready_s), 64'h0);
        chk({tag, " accept_busy"},     64'(busy_s),     64'h3);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 64'h0;
        if (hold > 0) begin
            bad = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                if (send_s != 2'b00) bad = 1'b1;
            end
            chk({tag, " send_low_while_tx_busy"}, 64'(bad), 64'h0);
            hold_low = 1'b0;
        end
        @(posedge clk); #1;
        chk({tag, " first_send"},     64'(send_s),    64'h3);
        chk({tag, " first_char_msb"}, 64'(tx_data_m), 64'(exp_q0[0]));
        chk({tag, " first_char_lsb"}, 64'(tx_data_l), 64'(exp_q1[0]));
        if (pulse) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
            end
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 64'h0;
        end
        timeout = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (done_s[0]) begin
                timeout = 1'b0;
                break;
            end
        end
        chk({tag, " done_timeout"}, 64'(timeout), 64'h0);
        chk({tag, " done_both"},    64'(done_s),  64'h3);
        @(posedge clk); #1;
        chk({tag, " after_done_in_ready"}, 64'(in_ready_s), 64'h3);
        chk({tag, " after_done_done"},     64'(done_s),     64'h0);
        chk({tag, " after_done_busy"},     64'(busy_s),     64'h0);
        @(negedge clk);
        check_streams(tag);
        chk({tag, " done_pulses_msb"}, 64'(done_cnt[0] - d0), 64'h1);
        chk({tag, " done_pulses_lsb"}, 64'(done_cnt[1] - d1), 64'h1);
        $display("block %s data=%016h sent msb=%0d lsb=%0d chars", tag, d, rx_q0.size(), rx_q1.size());
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [63:0] data;
        logic [63:0] exp_msb;   // byte sequence expected from the MSB_FIRST=1 instance
        logic [63:0] exp_lsb;   // byte sequence expected from the MSB_FIRST=0 instance
        int          hold;      // cycles tx_ready is held low at acceptance
        bit          pulse;     // re-pulse in_valid while busy
    } vec_t;

    vec_t vecs [3];

    initial begin
        logic [143:0] hex_lit;
        int           dc0, dc1;
        bit           to;

        vecs[0] = '{64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 64'hEFCDAB8967452301, 0,   1'b0};
        vecs[1] = '{64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 64'hEFCDAB8967452301, 100, 1'b0};
        vecs[2] = '{64'h1122334455667788, 64'h1122334455667788, 64'h8877665544332211, 0,   1'b1};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 64'(in_ready_s), 64'h3);
        chk("reset send",     64'(send_s),     64'h0);
        chk("reset busy",     64'(busy_s),     64'h0);
        chk("reset done",     64'(done_s),     64'h0);
        chk("reset tx_data",  64'({tx_data_m, tx_data_l}), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 3; v++) begin
            run_block(vecs[v].data, vecs[v].exp_msb, vecs[v].exp_lsb,
                      vecs[v].hold, vecs[v].pulse, $sformatf("vec%0d", v));
`ifdef DES_SER_HEX_ASCII_EN
            if (v == 0) begin
                hex_lit = 144'h303132333435363738394142434445460D0A;
                for (int k = 0; k < 18; k++)
                    chk($sformatf("hex_literal[%0d]", k),
                        (k < rx_q0.size()) ? 64'(rx_q0[k]) : 64'hBAD,
                        64'(hex_lit[143-8*k -: 8]));
            end
`endif
        end

        // Reset in the middle of a block, right after byte 3 is latched.
        rx_q0.delete();
        rx_q1.delete();
        @(negedge clk);
        in_data  = 64'h0123456789ABCDEF;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 64'h0;
        to = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (rx_q0.size() >= 3) begin
                to = 1'b0;
                break;
            end
        end
        chk("midblock wait_byte3", 64'(to), 64'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midblock_rst send",     64'(send_s),     64'h0);
        chk("midblock_rst busy",     64'(busy_s),     64'h0);
        chk("midblock_rst in_ready", 64'(in_ready_s), 64'h3);
        chk("midblock_rst done",     64'(done_s),     64'h0);
        @(negedge clk);
        rst = 1'b0;
        dc0 = done_cnt[0];
        dc1 = done_cnt[1];
        repeat (40) @(negedge clk);
        chk("midblock no_done_msb",   64'(done_cnt[0] - dc0), 64'h0);
        chk("midblock no_done_lsb",   64'(done_cnt[1] - dc1), 64'h0);
        chk("midblock chars_dropped", 64'(rx_q0.size()),      64'h3);
        $display("midblock reset: %0d chars reached the UART before reset", rx_q0.size());

        run_block(64'hA5A5A5A5A5A5A5A5, 64'hA5A5A5A5A5A5A5A5, 64'hA5A5A5A5A5A5A5A5,
                  0, 1'b0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
